alu_seq: RTL

Parametrised, registered successor to the combinational datapath ALU. It keeps the single-cycle integer ops and their control encoding, and adds an iterative signed/unsigned multiply/divide engine with HI/LO registers and a start/busy/done handshake. It sits in the EX stage: the control unit asserts `start` with an opcode, and the stall logic holds the pipeline while `busy` is high.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/muldiv_iter.sv | 90 +++++++++
 rtl/alu_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and defaults shared by alu_seq and muldiv_iter
package alu_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_MFHI  = 4'b0011;
    localparam logic [3:0] ALU_MFLO  = 4'b0100;
    localparam logic [3:0] ALU_LUI   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_BNE   = 4'b1010;
    localparam logic [3:0] ALU_DIV   = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_DIVU  = 4'b1101;
    localparam logic [3:0] ALU_BGEZ  = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    function automatic logic is_multi(input logic [3:0] op);
        return op inside {ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
    endfunction

    function automatic logic is_mul(input logic [3:0] op);
        return (op == ALU_MULT) || (op == ALU_MULTU);
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: shift-add multiply / restoring divide over magnitudes, one bit per cycle, with sign fixup
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, m_q, m_d, a_q, a_d;
    logic div_q, div_d, sa_q, sa_d, sb_q, sb_d, dz_q, dz_d, ov_q, ov_d;
    logic is_div, sgn, sa, sb, ge, step;
    logic [WIDTH-1:0] ma, mb, rdiff;
    logic [WIDTH:0] sum, rs;
    logic [2*WIDTH-1:0] prod;

    always_comb begin
        is_div = (op == ALU_DIV) || (op == ALU_DIVU);
        sgn = (op == ALU_MULT) || (op == ALU_DIV);
        sa = sgn && a[WIDTH-1];
        sb = sgn && b[WIDTH-1];
        ma = sa ? -a : a;
        mb = sb ? -b : b;
        sum = {1'b0, acc_q} + (sh_q[0] ? {1'b0, m_q} : '0);
        rs = {acc_q, sh_q[WIDTH-1]};
        ge = rs >= {1'b0, m_q};
        rdiff = rs[WIDTH-1:0] - m_q;
        step = cnt_q != '0;
        cnt_d = load ? CW'(WIDTH) : step ? cnt_q - CW'(1) : cnt_q;
        acc_d = load ? '0 : !step ? acc_q : div_q ? (ge ? rdiff : rs[WIDTH-1:0]) : sum[WIDTH:1];
        sh_d = load ? (is_div ? ma : mb) : !step ? sh_q
             : div_q ? {sh_q[WIDTH-2:0], ge} : {sum[0], sh_q[WIDTH-1:1]};
        m_d = load ? (is_div ? mb : ma) : m_q;
        a_d = load ? a : a_q;
        div_d = load ? is_div : div_q;
        sa_d = load ? sa : sa_q;
        sb_d = load ? sb : sb_q;
        dz_d = load ? (is_div && b == '0) : dz_q;
        ov_d = load ? (is_div && (b == '0 || (sgn && a == MINV && &b))) : ov_q;
    end

    // divide-by-zero bypasses the iteration result entirely
    always_comb begin
        prod = (sa_q ^ sb_q) ? -{acc_q, sh_q} : {acc_q, sh_q};
        hi = dz_q ? a_q : div_q ? (sa_q ? -acc_q : acc_q) : prod[2*WIDTH-1:WIDTH];
        lo = dz_q ? '1 : div_q ? ((sa_q ^ sb_q) ? -sh_q : sh_q) : prod[WIDTH-1:0];
        ovf = ov_q;
        busy = cnt_q != '0;
        fin = cnt_q == CW'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            acc_q <= '0;
            sh_q <= '0;
            m_q <= '0;
            a_q <= '0;
            div_q <= 1'b0;
            sa_q <= 1'b0;
            sb_q <= 1'b0;
            dz_q <= 1'b0;
            ov_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            sh_q <= sh_d;
            m_q <= m_d;
            a_q <= a_d;
            div_q <= div_d;
            sa_q <= sa_d;
            sb_q <= sb_d;
            dz_q <= dz_d;
            ov_q <= ov_d;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with single-cycle ops, iterative mul/div and HI/LO registers
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] salida1,
    input  logic [WIDTH-1:0] salida3,
    output logic [WIDTH-1:0] rd,
    output logic             overflow,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int MSB = WIDTH - 1;

    state_t state_q, state_d;
    logic [WIDTH-1:0] rd_q, rd_d, hi_q, hi_d, lo_q, lo_d;
    logic ovf_q, ovf_d, zero_q, zero_d, busy_q, busy_d, done_q, done_d;
    logic [WIDTH-1:0] res, sum, diff, it_hi, it_lo;
    logic res_ovf, issue, single, load, fix, iterating, it_busy, it_fin, it_ovf;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk (clk),
        .reset (reset),
        .load (load),
        .op (control),
        .a (salida1),
        .b (salida3),
        .busy (it_busy),
        .fin (it_fin),
        .hi (it_hi),
        .lo (it_lo),
        .ovf (it_ovf)
    );

    always_comb begin
        sum = salida1 + salida3;
        diff = salida1 - salida3;
        res = sum;
        res_ovf = 1'b0;
        case (control)
            ALU_AND:  res = salida1 & salida3;
            ALU_OR:   res = salida1 | salida3;
            ALU_NOR:  res = ~(salida1 | salida3);
            ALU_ADD:  res_ovf = (salida1[MSB] == salida3[MSB]) && (sum[MSB] != salida1[MSB]);
            ALU_SUB: begin
                res = diff;
                res_ovf = (salida1[MSB] != salida3[MSB]) && (diff[MSB] != salida1[MSB]);
            end
            ALU_SLT:  res = WIDTH'($signed(salida1) < $signed(salida3));
            ALU_LUI:  res = salida3 << (WIDTH / 2);
            ALU_BGEZ: res = WIDTH'(salida1[MSB]);
            ALU_BNE:  res = WIDTH'(salida1 == salida3);
            ALU_MFHI: res = hi_q;
            ALU_MFLO: res = lo_q;
            default:  res = sum;
        endcase
    end

    always_comb begin
        issue = (state_q == S_IDLE) && start;
        single = issue && !is_multi(control);
        load = issue && is_multi(control);
        fix = state_q == S_FIX;
        iterating = (state_q == S_MUL) || (state_q == S_DIV);
        state_d = load ? (is_mul(control) ? S_MUL : S_DIV)
                : fix ? S_IDLE
                : (iterating && (it_fin || !it_busy)) ? S_FIX : state_q;
        rd_d = single ? res : rd_q;
        zero_d = single ? (res == '0) : zero_q;
        ovf_d = single ? res_ovf : fix ? it_ovf : ovf_q;
        hi_d = fix ? it_hi : hi_q;
        lo_d = fix ? it_lo : lo_q;
        busy_d = state_d != S_IDLE;
        done_d = single || fix;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rd_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
            ovf_q <= 1'b0;
            zero_q <= 1'b1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q <= rd_d;
            hi_q <= hi_d;
            lo_q <= lo_d;
            ovf_q <= ovf_d;
            zero_q <= zero_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign rd = rd_q;
    assign hi = hi_q;
    assign lo = lo_q;
    assign overflow = ovf_q;
    assign zero = zero_q;
    assign busy = busy_q;
    assign done = done_q;
endmodule
